// File: rtl/cpu_io_switch_matrix_cfg.sv
// CPU IO-tile switch matrix with a serially loaded, double-buffered configuration.
// The shadow register shifts in bit-serially; the active register drives the muxes.
module cpu_io_switch_matrix_cfg #(
   parameter  int W        = 4,
   parameter  int N_RES    = 3,
   parameter  int N_W6     = 3,
   localparam int CFG_BITS = 3 * N_RES + 2 * N_W6,
   localparam int CNT_W    = $clog2(CFG_BITS + 2)
) (
   input  logic                 UserCLK,
   input  logic                 resetn,
   input  logic                 ConfigIn,
   input  logic                 ConfigEn,
   input  logic                 ConfigLatch,
   input  logic [N_RES*W-1:0]   E6END,
   input  logic [W-1:0]         OPA_O,
   input  logic [W-1:0]         OPB_O,
   output logic [N_RES*W-1:0]   RES_I,
   output logic [N_W6*W-1:0]    W6BEG,
   output logic [CNT_W-1:0]     ConfigCount,
   output logic                 ConfigErr
);

   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CFG_BITS);
   localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(CFG_BITS + 1);

   logic [CFG_BITS-1:0] shadow_q, shadow_d;
   logic [CFG_BITS-1:0] active_q, active_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                err_q, err_d;
   logic [W-1:0]        opa_q, opa_d;

   // Latch wins over a simultaneous shift and judges the pre-edge count and shadow.
   always_comb begin
      shadow_d = shadow_q;
      active_d = active_q;
      cnt_d    = cnt_q;
      err_d    = err_q;
      opa_d    = OPA_O;
      if (ConfigLatch) begin
         cnt_d = '0;
         if (cnt_q == CNT_FULL) begin
            active_d = shadow_q;
            err_d    = 1'b0;
         end else begin
            err_d = 1'b1;
         end
      end else if (ConfigEn) begin
         shadow_d = {shadow_q[CFG_BITS-2:0], ConfigIn};
         err_d    = 1'b0;
         if (cnt_q != CNT_SAT) begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge UserCLK or negedge resetn) begin
      if (!resetn) begin
         shadow_q <= '0;
         active_q <= '0;
         cnt_q    <= '0;
         err_q    <= 1'b0;
         opa_q    <= '0;
      end else begin
         shadow_q <= shadow_d;
         active_q <= active_d;
         cnt_q    <= cnt_d;
         err_q    <= err_d;
         opa_q    <= opa_d;
      end
   end

   assign ConfigCount = cnt_q;
   assign ConfigErr   = err_q;

   for (genvar k = 0; k < N_RES; k++) begin : g_res
      localparam int KN = (k + 1) % N_RES;
      logic [1:0]   sel;
      logic         reg_mode;
      logic [W-1:0] sel_val;
      logic [W-1:0] res_d;
      logic [W-1:0] res_q;

      assign sel      = active_q[3*k +: 2];
      assign reg_mode = active_q[3*k+2];

      // sel = 3 selects the channel's own flop, so the hold falls out of the mux.
      always_comb begin
         case (sel)
            2'd0:    sel_val = E6END[k*W +: W];
            2'd1:    sel_val = E6END[KN*W +: W];
            2'd2:    sel_val = '0;
            default: sel_val = res_q;
         endcase
         res_d = sel_val;
      end

      always_ff @(posedge UserCLK or negedge resetn) begin
         if (!resetn) begin
            res_q <= '0;
         end else begin
            res_q <= res_d;
         end
      end

      assign RES_I[k*W +: W] = (reg_mode || (sel == 2'd3)) ? res_q : sel_val;
   end

   for (genvar g = 0; g < N_W6; g++) begin : g_w6
      logic [1:0]   wsel;
      logic [W-1:0] w6_val;

      assign wsel = active_q[3*N_RES + 2*g +: 2];

      always_comb begin
         case (wsel)
            2'd0:    w6_val = '0;
            2'd1:    w6_val = OPA_O;
            2'd2:    w6_val = OPB_O;
            default: w6_val = opa_q;
         endcase
      end

      assign W6BEG[g*W +: W] = w6_val;
   end

endmodule
